// File: rtl/bramac_pkg.sv
// Shared definitions for the BrAMAC job sequencer: instruction-word bit positions,
// precision modes, sequencer states and the mode-to-precision helper.
package bramac_pkg;

  localparam int INST_W       = 40;
  localparam int INST_RST     = 24;
  localparam int INST_START   = 23;
  localparam int INST_DONE    = 22;
  localparam int INST_COPY    = 21;
  localparam int INST_MODE_HI = 20;
  localparam int INST_MODE_LO = 19;
  localparam int INST_ROW_HI  = 18;
  localparam int INST_ROW_LO  = 12;
  localparam int INST_COL1_HI = 11;
  localparam int INST_COL1_LO = 10;
  localparam int INST_COL2_HI = 9;
  localparam int INST_COL2_LO = 8;
  localparam int INST_IN_HI   = 7;
  localparam int INST_IN_LO   = 0;

  typedef enum logic [1:0] {
    MODE_ILLEGAL = 2'b00,
    MODE_2B      = 2'b01,
    MODE_4B      = 2'b10,
    MODE_8B      = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_START,
    S_MODE,
    S_W1,
    S_W2,
    S_ITER,
    S_WAIT
  } seq_state_t;

  // Operand precision P in bits; the engine spends P cycles on bit-serial products.
  function automatic logic [3:0] mode_to_prec(input mode_t m);
    case (m)
      MODE_2B: return 4'd2;
      MODE_4B: return 4'd4;
      MODE_8B: return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/bramac_act_fifo.sv
// Activation byte FIFO with occupancy count and combinational head read.
// A push on a full FIFO is accepted only when a pop frees a slot in the same cycle.
module bramac_act_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [7:0]       din,
  input  logic             pop,
  output logic [7:0]       dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = CNT_W - 1;

  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  assign dout  = mem[rd_ptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/bramac_mac_sequencer.sv
// Job-level controller that drives one compute-mode M20K MAC engine with a registered
// instruction word. Optional perf counters are enabled by BRAMAC_SEQ_PERF_EN.
module bramac_mac_sequencer
  import bramac_pkg::*;
#(
  parameter int ACT_DEPTH = 16,
  parameter int MAX_ITER  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [1:0]        job_mode,
  input  logic [6:0]        job_niter,
  input  logic [6:0]        job_row,
  input  logic [1:0]        job_col1,
  input  logic [1:0]        job_col2,
  input  logic              act_valid,
  output logic              act_ready,
  input  logic [7:0]        act_data,
  output logic              comp_en,
  output logic [INST_W-1:0] inst,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              err
`ifdef BRAMAC_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [15:0]       perf_jobs
`endif
);

  localparam int CNT_W = $clog2(ACT_DEPTH) + 1;

  // Handshakes: a transfer happens on a clock edge where valid and ready are both high;
  // job_ready is high only in S_IDLE and act_ready only while the FIFO has a free slot.

  seq_state_t        state_q, state_d;
  mode_t             mode_q, mode_d;
  logic [6:0]        niter_q, niter_d;
  logic [6:0]        row_q, row_d;
  logic [1:0]        col1_q, col1_d;
  logic [1:0]        col2_q, col2_d;
  logic [6:0]        k_q, k_d;
  logic [3:0]        off_q, off_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              err_q, err_d;

  logic              pop_req;
  logic              job_legal;
  logic              not_last;
  logic [3:0]        add_off, last_off;
  logic [7:0]        fifo_dout;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  bramac_act_fifo #(
    .DEPTH (ACT_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (act_valid && act_ready),
    .din   (act_data),
    .pop   (pop_req),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign add_off   = mode_to_prec(mode_q) + 4'd1;
  assign last_off  = mode_to_prec(mode_q) + 4'd2;
  assign job_legal = (job_mode != 2'b00) && (job_niter != 7'd0) && (int'(job_niter) <= MAX_ITER);

  // inst_d describes the cycle the FSM is entering, so inst always lines up with state_q.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    niter_d  = niter_q;
    row_d    = row_q;
    col1_d   = col1_q;
    col2_d   = col2_q;
    k_d      = k_q;
    off_d    = off_q;
    inst_d   = '0;
    err_d    = err_q;
    pop_req  = 1'b0;
    not_last = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          if (job_legal) begin
            state_d          = S_RST;
            mode_d           = mode_t'(job_mode);
            niter_d          = job_niter;
            row_d            = job_row;
            col1_d           = job_col1;
            col2_d           = job_col2;
            inst_d[INST_RST] = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RST: begin
        // The engine cannot stall, so the first weight pair's activations must be on hand.
        if (fifo_count >= CNT_W'(2)) begin
          state_d            = S_START;
          inst_d[INST_START] = 1'b1;
        end else begin
          inst_d[INST_RST] = 1'b1;
        end
      end
      S_START: begin
        state_d                           = S_MODE;
        inst_d[INST_MODE_HI:INST_MODE_LO] = mode_q;
      end
      S_MODE: begin
        state_d                           = S_W1;
        inst_d[INST_ROW_HI:INST_ROW_LO]   = row_q;
        inst_d[INST_COL1_HI:INST_COL1_LO] = col1_q;
        pop_req                           = 1'b1;
      end
      S_W1: begin
        state_d                           = S_W2;
        inst_d[INST_ROW_HI:INST_ROW_LO]   = row_q;
        inst_d[INST_COL2_HI:INST_COL2_LO] = col2_q;
        pop_req                           = 1'b1;
      end
      S_W2: begin
        state_d = S_ITER;
        k_d     = 7'd0;
        off_d   = 4'd0;
      end
      S_ITER: begin
        if (off_q == last_off) begin
          if (k_q == niter_q - 7'd1) begin
            state_d = S_WAIT;
          end else begin
            k_d   = k_q + 7'd1;
            off_d = 4'd0;
          end
        end else begin
          off_d = off_q + 4'd1;
        end
        not_last = (k_d != niter_q - 7'd1);
        if (state_d == S_ITER) begin
          if (off_d == add_off && not_last) begin
            inst_d[INST_COPY]                 = 1'b1;
            inst_d[INST_ROW_HI:INST_ROW_LO]   = row_q + k_d + 7'd1;
            inst_d[INST_COL1_HI:INST_COL1_LO] = col1_q;
            pop_req                           = 1'b1;
          end else if (off_d == last_off) begin
            if (not_last) pop_req = 1'b1;
            else inst_d[INST_DONE] = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Underrun feeds a zero byte to the engine and flags the job rather than stalling.
    if (pop_req) begin
      inst_d[INST_IN_HI:INST_IN_LO] = fifo_empty ? 8'h00 : fifo_dout;
      if (fifo_empty) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_ILLEGAL;
      niter_q <= '0;
      row_q   <= '0;
      col1_q  <= '0;
      col2_q  <= '0;
      k_q     <= '0;
      off_q   <= '0;
      inst_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      niter_q <= niter_d;
      row_q   <= row_d;
      col1_q  <= col1_d;
      col2_q  <= col2_d;
      k_q     <= k_d;
      off_q   <= off_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
    end
  end

  assign job_ready = (state_q == S_IDLE);
  assign act_ready = !fifo_full;
  assign comp_en   = (state_q != S_IDLE);
  assign res_valid = (state_q == S_WAIT);
  assign inst      = inst_q;
  assign err       = err_q;

`ifdef BRAMAC_SEQ_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [15:0] perf_jobs_q, perf_jobs_d;

  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_jobs_d   = perf_jobs_q;
    if (state_q != S_IDLE && perf_cycles_q != '1) perf_cycles_d = perf_cycles_q + 32'd1;
    if (state_q == S_WAIT && res_ready && perf_jobs_q != '1) perf_jobs_d = perf_jobs_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles_q <= '0;
      perf_jobs_q   <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_jobs_q   <= perf_jobs_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_jobs   = perf_jobs_q;
`endif

endmodule

// File: tb/tb_bramac_mac_sequencer.sv
// Directed bench for bramac_mac_sequencer: builds the expected instruction stream per job
// from the engine schedule and compares it cycle by cycle against the DUT.
module tb_bramac_mac_sequencer;

  logic        clk;
  logic        rst;
  logic        job_valid;
  logic        job_ready;
  logic [1:0]  job_mode;
  logic [6:0]  job_niter;
  logic [6:0]  job_row;
  logic [1:0]  job_col1;
  logic [1:0]  job_col2;
  logic        act_valid;
  logic        act_ready;
  logic [7:0]  act_data;
  logic        comp_en;
  logic [39:0] inst;
  logic        res_valid;
  logic        res_ready;
  logic        err;
`ifdef BRAMAC_SEQ_PERF_EN
  logic [31:0] perf_cycles;
  logic [15:0] perf_jobs;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int start_cyc    = 0;
  int done_cyc     = 0;

  logic [39:0] exp_q[$];
  logic [7:0]  act_q[$];

  bramac_mac_sequencer #(
    .ACT_DEPTH (16),
    .MAX_ITER  (64)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .job_valid   (job_valid),
    .job_ready   (job_ready),
    .job_mode    (job_mode),
    .job_niter   (job_niter),
    .job_row     (job_row),
    .job_col1    (job_col1),
    .job_col2    (job_col2),
    .act_valid   (act_valid),
    .act_ready   (act_ready),
    .act_data    (act_data),
    .comp_en     (comp_en),
    .inst        (inst),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .err         (err)
`ifdef BRAMAC_SEQ_PERF_EN
    ,
    .perf_cycles (perf_cycles),
    .perf_jobs   (perf_jobs)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [39:0] mk(input logic r, input logic s, input logic d, input logic c,
                                     input logic [1:0] m, input logic [6:0] row,
                                     input logic [1:0] c1, input logic [1:0] c2,
                                     input logic [7:0] in);
    logic [39:0] w;
    w        = '0;
    w[24]    = r;
    w[23]    = s;
    w[22]    = d;
    w[21]    = c;
    w[20:19] = m;
    w[18:12] = row;
    w[11:10] = c1;
    w[9:8]   = c2;
    w[7:0]   = in;
    return w;
  endfunction

  function automatic logic [7:0] take();
    if (act_q.size() != 0) return act_q.pop_front();
    return 8'h00;
  endfunction

  // Driver tasks
  task automatic push_act(input logic [7:0] b);
    act_valid = 1'b1;
    act_data  = b;
    act_q.push_back(b);
    step();
    act_valid = 1'b0;
  endtask

  task automatic set_job(input logic [1:0] m, input logic [6:0] n, input logic [6:0] row,
                         input logic [1:0] c1, input logic [1:0] c2);
    job_mode  = m;
    job_niter = n;
    job_row   = row;
    job_col1  = c1;
    job_col2  = c2;
    job_valid = 1'b1;
  endtask

  // Expected instruction stream for one job, following the engine's state schedule
  task automatic build_job(input logic [1:0] m, input int n, input logic [6:0] row,
                           input logic [1:0] c1, input logic [1:0] c2, input bit with_rst);
    int         p;
    logic [6:0] r;
    p = (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 8;
    if (with_rst) exp_q.push_back(mk(1, 0, 0, 0, 2'b00, 7'd0, 2'd0, 2'd0, 8'h00));
    exp_q.push_back(mk(0, 1, 0, 0, 2'b00, 7'd0, 2'd0, 2'd0, 8'h00));
    exp_q.push_back(mk(0, 0, 0, 0, m, 7'd0, 2'd0, 2'd0, 8'h00));
    exp_q.push_back(mk(0, 0, 0, 0, 2'b00, row, c1, 2'd0, take()));
    exp_q.push_back(mk(0, 0, 0, 0, 2'b00, row, 2'd0, c2, take()));
    for (int k = 0; k < n; k++) begin
      for (int off = 0; off <= p + 2; off++) begin
        r = row + 7'(k + 1);
        if (off == p + 1 && k < n - 1)
          exp_q.push_back(mk(0, 0, 0, 1, 2'b00, r, c1, 2'd0, take()));
        else if (off == p + 2 && k < n - 1)
          exp_q.push_back(mk(0, 0, 0, 0, 2'b00, 7'd0, 2'd0, 2'd0, take()));
        else if (off == p + 2)
          exp_q.push_back(mk(0, 0, 1, 0, 2'b00, 7'd0, 2'd0, 2'd0, 8'h00));
        else
          exp_q.push_back(40'd0);
      end
    end
  endtask

  // Scoreboard: one expected word per cycle
  task automatic drain_n(input int n);
    logic [39:0] e;
    for (int i = 0; i < n; i++) begin
      step();
      job_valid = 1'b0;
      e = exp_q.pop_front();
      chk("inst", {23'd0, comp_en, inst}, {23'd0, 1'b1, e});
      if (inst[23]) start_cyc = cyc;
      if (inst[22]) done_cyc = cyc;
    end
  endtask

  task automatic finish_job();
    step();
    chk("wait_res_valid", 64'(res_valid), 64'd1);
    chk("wait_inst", 64'(inst), 64'd0);
    step();
    chk("wait_res_held", 64'(res_valid), 64'd1);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("done_res_valid", 64'(res_valid), 64'd0);
    chk("done_job_ready", 64'(job_ready), 64'd1);
    chk("done_comp_en", 64'(comp_en), 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    job_valid = 1'b0;
    job_mode  = 2'b00;
    job_niter = 7'd0;
    job_row   = 7'd0;
    job_col1  = 2'd0;
    job_col2  = 2'd0;
    act_valid = 1'b0;
    act_data  = 8'h00;
    res_ready = 1'b0;
    step();
    step();
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_comp_en", 64'(comp_en), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    step();
    chk("idle_job_ready", 64'(job_ready), 64'd1);
    chk("idle_act_ready", 64'(act_ready), 64'd1);

    // 4b job, N=1
    push_act(8'hA1);
    push_act(8'hB2);
    build_job(2'b10, 1, 7'd5, 2'd1, 2'd2, 1'b1);
    set_job(2'b10, 7'd1, 7'd5, 2'd1, 2'd2);
    drain_n(exp_q.size());
    finish_job();
    chk("t1_err", 64'(err), 64'd0);

    // 8b job, N=3, row wraps from 0x7F to 0x00
    push_act(8'h11);
    push_act(8'h22);
    push_act(8'h33);
    push_act(8'h44);
    push_act(8'h55);
    push_act(8'h66);
    build_job(2'b11, 3, 7'h7E, 2'd3, 2'd0, 1'b1);
    set_job(2'b11, 7'd3, 7'h7E, 2'd3, 2'd0);
    drain_n(exp_q.size());
    chk("t2_start_to_done", 64'(done_cyc - start_cyc + 1), 64'd37);
    finish_job();
    chk("t2_err", 64'(err), 64'd0);

    // FIFO empty at accept: hold in S_RST until two bytes arrive
    set_job(2'b10, 7'd1, 7'd9, 2'd0, 2'd3);
    step();
    job_valid = 1'b0;
    chk("t5_rst0", 64'(inst), 64'(mk(1, 0, 0, 0, 2'b00, 7'd0, 2'd0, 2'd0, 8'h00)));
    step();
    chk("t5_rst1", 64'(inst), 64'(mk(1, 0, 0, 0, 2'b00, 7'd0, 2'd0, 2'd0, 8'h00)));
    push_act(8'hC1);
    chk("t5_rst2", 64'(inst), 64'(mk(1, 0, 0, 0, 2'b00, 7'd0, 2'd0, 2'd0, 8'h00)));
    push_act(8'hC2);
    chk("t5_rst3", 64'(inst), 64'(mk(1, 0, 0, 0, 2'b00, 7'd0, 2'd0, 2'd0, 8'h00)));
    build_job(2'b10, 1, 7'd9, 2'd0, 2'd3, 1'b0);
    drain_n(exp_q.size());
    finish_job();

    // Reset in S_ITER with stale bytes left in the FIFO
    push_act(8'h81);
    push_act(8'h82);
    push_act(8'h83);
    push_act(8'h84);
    build_job(2'b10, 1, 7'd2, 2'd1, 2'd1, 1'b1);
    set_job(2'b10, 7'd1, 7'd2, 2'd1, 2'd1);
    drain_n(7);
    rst = 1'b1;
    #1;
    chk("t6_async_inst", 64'(inst), 64'd0);
    chk("t6_async_comp_en", 64'(comp_en), 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("t6_job_ready", 64'(job_ready), 64'd1);
    chk("t6_inst", 64'(inst), 64'd0);
    exp_q.delete();
    act_q.delete();
    push_act(8'hD3);
    push_act(8'hD4);
    build_job(2'b10, 1, 7'd3, 2'd2, 2'd1, 1'b1);
    set_job(2'b10, 7'd1, 7'd3, 2'd2, 2'd1);
    drain_n(exp_q.size());
    finish_job();
    chk("t6_err", 64'(err), 64'd0);

    // 2b job, N=2 with only three bytes: fourth pop underruns
    push_act(8'h5A);
    push_act(8'h6B);
    push_act(8'h7C);
    chk("t4_err_before", 64'(err), 64'd0);
    build_job(2'b01, 2, 7'h10, 2'd2, 2'd1, 1'b1);
    set_job(2'b01, 7'd2, 7'h10, 2'd2, 2'd1);
    drain_n(exp_q.size());
    chk("t4_err_after", 64'(err), 64'd1);
    finish_job();

    // Illegal descriptors are dropped with err set
    do_reset();
    chk("t3_err_cleared", 64'(err), 64'd0);
    set_job(2'b00, 7'd1, 7'd4, 2'd1, 2'd1);
    step();
    job_valid = 1'b0;
    chk("t3_mode0_err", 64'(err), 64'd1);
    chk("t3_mode0_inst", 64'(inst), 64'd0);
    chk("t3_mode0_job_ready", 64'(job_ready), 64'd1);
    chk("t3_mode0_comp_en", 64'(comp_en), 64'd0);
    step();
    chk("t3_mode0_inst_later", 64'(inst), 64'd0);

    do_reset();
    set_job(2'b10, 7'd0, 7'd4, 2'd1, 2'd1);
    step();
    job_valid = 1'b0;
    chk("t3_niter0_err", 64'(err), 64'd1);
    chk("t3_niter0_job_ready", 64'(job_ready), 64'd1);

    do_reset();
    set_job(2'b10, 7'd65, 7'd4, 2'd1, 2'd1);
    step();
    job_valid = 1'b0;
    chk("t3_niter65_err", 64'(err), 64'd1);
    chk("t3_niter65_inst", 64'(inst), 64'd0);

    do_reset();
    set_job(2'b01, 7'd64, 7'd4, 2'd1, 2'd1);
    step();
    job_valid = 1'b0;
    chk("t3_niter64_inst", 64'(inst), 64'(mk(1, 0, 0, 0, 2'b00, 7'd0, 2'd0, 2'd0, 8'h00)));
    chk("t3_niter64_err", 64'(err), 64'd0);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
